// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sharing of one barrel shifter between two requesters with a single result slot
module shift_arbiter #(
  parameter int WIDTH = 32,
  parameter int RR_INIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [4:0]       req_shamt0,
  input  logic [1:0]       req_type0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [4:0]       req_shamt1,
  input  logic [1:0]       req_type1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic owner, rr_ptr, slot_free, sel;
  logic [1:0] gnt, acc, op_type;
  logic [4:0] op_shamt;
  logic [WIDTH-1:0] op_a, res;
  always_comb begin
    slot_free = state == EMPTY || rsp_ready[owner];
    gnt = &req_valid ? (rr_ptr ? 2'b10 : 2'b01) : req_valid;
    req_ready = (rst || !slot_free) ? 2'b00 : gnt;
    acc = req_valid & req_ready;
    sel = acc[1];
    op_a = sel ? req_a1 : req_a0;
    op_shamt = sel ? req_shamt1 : req_shamt0;
    op_type = sel ? req_type1 : req_type0;
    rsp_valid = state == FULL ? (owner ? 2'b10 : 2'b01) : 2'b00;
  end
  shift_unit #(.WIDTH(WIDTH)) u_shift (
    .a(op_a),
    .shamt(op_shamt),
    .op(op_type),
    .y(res)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      owner <= 1'b0;
      rr_ptr <= 1'(RR_INIT);
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else if (|acc) begin
      state <= FULL;
      owner <= sel;
      rr_ptr <= ~sel;
      rsp_data <= res;
      rsp_err <= &op_type;
    end else if (state == FULL && rsp_ready[owner]) begin
      state <= EMPTY;
    end
  end
endmodule

module shift_unit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [4:0]       shamt,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] sra;
  always_comb begin
    sra = $signed(a) >>> shamt;
    y = op == 2'b00 ? a >> shamt : op == 2'b01 ? a << shamt : op == 2'b10 ? sra : a;
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: scoreboard-driven bench for the shared shifter arbiter
module tb_shift_arbiter;
  logic clk = 0;
  logic rst = 1;
  logic [1:0] rv = 0, rr = 0, t0 = 0, t1 = 0;
  logic [31:0] a0 = 0, a1 = 0;
  logic [4:0] s0 = 0, s1 = 0;
  logic [1:0] qready, rspv;
  logic [31:0] rdata;
  logic rerr;
  int checks = 0, fails = 0;
  logic last_p = 0;
  typedef struct {logic p; logic [31:0] d; logic e;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  shift_arbiter #(.WIDTH(32), .RR_INIT(0)) dut (
    .clk(clk), .rst(rst), .req_valid(rv), .req_ready(qready),
    .req_a0(a0), .req_shamt0(s0), .req_type0(t0),
    .req_a1(a1), .req_shamt1(s1), .req_type1(t1),
    .rsp_valid(rspv), .rsp_ready(rr), .rsp_data(rdata), .rsp_err(rerr)
  );

  function automatic logic [32:0] model(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] t);
    logic [63:0] w;
    case (t)
      2'b00: w = {32'h0, a} >> sh;
      2'b01: w = {32'h0, a} << sh;
      2'b10: w = {{32{a[31]}}, a} >> sh;
      default: return {1'b1, a};
    endcase
    return {1'b0, w[31:0]};
  endfunction

  task automatic push_acc();
    for (int i = 0; i < 2; i++)
      if (rv[i] && qready[i]) begin
        logic [32:0] m;
        exp_t e;
        m = i ? model(a1, s1, t1) : model(a0, s0, t0);
        e.p = i[0];
        e.d = m[31:0];
        e.e = m[32];
        q.push_back(e);
        last_p = i[0];
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rv = 2'b11;
    rr = 2'b11;
    #12;
    checks++; if (rspv !== 2'b00) begin fails++; $display("FAIL reset_valid: got %b want 00", rspv); end
    checks++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", rdata); end
    checks++; if (rerr !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", rerr); end
    checks++; if (qready !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", qready); end
    step();
    rst = 0;
    rv = 0;
  endtask

  task automatic test_single();
    exp_t e;
    rv = 2'b01; a0 = 32'h8000_00F0; s0 = 4; t0 = 2'b10; rr = 2'b11;
    @(negedge clk);
    checks++; if (qready !== 2'b01) begin fails++; $display("FAIL single_ready: got %b want 01", qready); end
    push_acc();
    step();
    rv = 0;
    @(negedge clk);
    checks++; if (rdata !== 32'hF800_000F) begin fails++; $display("FAIL single_const: got %h want f800000f", rdata); end
    checks++;
    if (q.size() == 0) begin fails++; $display("FAIL single_rsp: response with empty scoreboard"); end
    else begin
      e = q.pop_front();
      if (rspv !== (e.p ? 2'b10 : 2'b01) || rdata !== e.d || rerr !== e.e) begin
        fails++; $display("FAIL single_rsp: got v=%b d=%h e=%b want p=%b d=%h e=%b", rspv, rdata, rerr, e.p, e.d, e.e);
      end
    end
    step();
    @(negedge clk);
    checks++; if (rspv !== 2'b00) begin fails++; $display("FAIL single_drain: got %b want 00", rspv); end
    step();
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic [1:0] want;
    rv = 2'b11; a0 = 32'h1; s0 = 31; t0 = 2'b01; a1 = 32'hFFFF_FFFF; s1 = 1; t1 = 2'b00; rr = 2'b11;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      want = last_p ? 2'b01 : 2'b10;
      checks++; if (qready !== want) begin fails++; $display("FAIL rr_grant%0d: got %b want %b", n, qready, want); end
      if (n > 0) begin
        checks++;
        if (q.size() == 0) begin fails++; $display("FAIL rr_rsp%0d: response with empty scoreboard", n); end
        else begin
          e = q.pop_front();
          if (rspv !== (e.p ? 2'b10 : 2'b01) || rdata !== e.d || rerr !== e.e) begin
            fails++; $display("FAIL rr_rsp%0d: got v=%b d=%h e=%b want p=%b d=%h e=%b", n, rspv, rdata, rerr, e.p, e.d, e.e);
          end
        end
      end
      push_acc();
      step();
    end
    rv = 0;
    @(negedge clk);
    checks++;
    e = q.pop_front();
    if (rspv !== (e.p ? 2'b10 : 2'b01) || rdata !== e.d) begin
      fails++; $display("FAIL rr_last: got v=%b d=%h want p=%b d=%h", rspv, rdata, e.p, e.d);
    end
    step();
  endtask

  task automatic test_backpressure();
    exp_t e;
    rv = 2'b10; a1 = 32'h0000_00FF; s1 = 4; t1 = 2'b01; rr = 2'b00;
    @(negedge clk);
    checks++; if (qready !== 2'b10) begin fails++; $display("FAIL bp_first: got %b want 10", qready); end
    push_acc();
    step();
    rv = 2'b01; a0 = 32'hF000_0000; s0 = 28; t0 = 2'b00;
    for (int k = 0; k < 3; k++) begin
      rr = (k == 1) ? 2'b01 : 2'b00;
      @(negedge clk);
      checks++;
      if (qready !== 2'b00 || rspv !== 2'b10 || rdata !== 32'h0000_0FF0) begin
        fails++; $display("FAIL bp_hold%0d: got ready=%b v=%b d=%h want ready=00 v=10 d=00000ff0", k, qready, rspv, rdata);
      end
      step();
    end
    rr = 2'b10;
    @(negedge clk);
    checks++; if (qready !== 2'b01) begin fails++; $display("FAIL bp_release: got %b want 01", qready); end
    for (int k = 0; k < 2; k++) begin
      if (k == 1) @(negedge clk);
      checks++;
      if (q.size() == 0) begin fails++; $display("FAIL bp_rsp%0d: response with empty scoreboard", k); end
      else begin
        e = q.pop_front();
        if (rspv !== (e.p ? 2'b10 : 2'b01) || rdata !== e.d || rerr !== e.e) begin
          fails++; $display("FAIL bp_rsp%0d: got v=%b d=%h e=%b want p=%b d=%h e=%b", k, rspv, rdata, rerr, e.p, e.d, e.e);
        end
      end
      push_acc();
      step();
      rv = 0;
      rr = 2'b11;
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    rv = 2'b10; a1 = 32'h1234_5678; s1 = 8; t1 = 2'b11; rr = 2'b11;
    @(negedge clk);
    push_acc();
    step();
    a1 = 32'h8000_0000; s1 = 4; t1 = 2'b10;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (k == 0 && (rspv !== 2'b10 || rdata !== 32'h1234_5678 || rerr !== 1'b1)) begin
        fails++; $display("FAIL illegal_const: got v=%b d=%h e=%b want v=10 d=12345678 e=1", rspv, rdata, rerr);
      end
      if (k == 1 && (rspv !== 2'b10 || rdata !== 32'hF800_0000 || rerr !== 1'b0)) begin
        fails++; $display("FAIL legal_after: got v=%b d=%h e=%b want v=10 d=f8000000 e=0", rspv, rdata, rerr);
      end
      checks++;
      e = q.pop_front();
      if (rspv !== (e.p ? 2'b10 : 2'b01) || rdata !== e.d || rerr !== e.e) begin
        fails++; $display("FAIL illegal_rsp%0d: got v=%b d=%h e=%b want p=%b d=%h e=%b", k, rspv, rdata, rerr, e.p, e.d, e.e);
      end
      push_acc();
      step();
      rv = 0;
    end
  endtask

  task automatic test_boundaries();
    exp_t e;
    logic [31:0] ta[9];
    logic [4:0] ts[9];
    logic [1:0] tt[9];
    ta = '{32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0};
    ts = '{5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 0, 0, 0, 0};
    tt = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 0, 0, 0, 0};
    for (int i = 5; i < 9; i++) begin
      ta[i] = $urandom;
      ts[i] = 5'($urandom_range(31));
      tt[i] = 2'($urandom_range(2));
    end
    rr = 2'b11;
    for (int n = 0; n <= 9; n++) begin
      if (n < 9) begin rv = 2'b01; a0 = ta[n]; s0 = ts[n]; t0 = tt[n]; end
      else rv = 0;
      @(negedge clk);
      if (n < 9) begin
        checks++; if (qready !== 2'b01) begin fails++; $display("FAIL bnd_ready%0d: got %b want 01", n, qready); end
      end
      if (n > 0) begin
        checks++;
        if (q.size() == 0) begin fails++; $display("FAIL bnd_rsp%0d: response with empty scoreboard", n - 1); end
        else begin
          e = q.pop_front();
          if (rspv !== (e.p ? 2'b10 : 2'b01) || rdata !== e.d || rerr !== e.e) begin
            fails++; $display("FAIL bnd_rsp%0d: got v=%b d=%h e=%b want p=%b d=%h e=%b", n - 1, rspv, rdata, rerr, e.p, e.d, e.e);
          end
        end
      end
      push_acc();
      step();
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    rv = 2'b01; a0 = 32'h5; s0 = 1; t0 = 2'b01; rr = 2'b00;
    @(negedge clk);
    push_acc();
    step();
    rv = 0;
    @(negedge clk);
    checks++; if (rspv !== 2'b01) begin fails++; $display("FAIL ar_full: got %b want 01", rspv); end
    #2;
    rst = 1;
    #1;
    checks++;
    if (rspv !== 2'b00 || rdata !== 32'h0 || rerr !== 1'b0 || qready !== 2'b00) begin
      fails++; $display("FAIL ar_clear: got v=%b d=%h e=%b ready=%b want v=00 d=0 e=0 ready=00", rspv, rdata, rerr, qready);
    end
    q.delete();
    step();
    rst = 0;
    rv = 2'b11; a0 = 32'h0F0F_0000; s0 = 8; t0 = 2'b00; a1 = 32'h3; s1 = 2; t1 = 2'b01; rr = 2'b11;
    @(negedge clk);
    checks++; if (qready !== 2'b01) begin fails++; $display("FAIL ar_first_grant: got %b want 01", qready); end
    push_acc();
    step();
    rv = 0;
    @(negedge clk);
    checks++;
    if (q.size() == 0) begin fails++; $display("FAIL ar_rsp: response with empty scoreboard"); end
    else begin
      e = q.pop_front();
      if (rspv !== (e.p ? 2'b10 : 2'b01) || rdata !== e.d || rerr !== e.e) begin
        fails++; $display("FAIL ar_rsp: got v=%b d=%h e=%b want p=%b d=%h e=%b", rspv, rdata, rerr, e.p, e.d, e.e);
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_illegal();
    test_boundaries();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
